// File: rtl/lsp_expand_2.sv
// Lsp_expand_2: forward pass over LSP pairs buf[NC-1..M-1] in scratch memory,
// pushing apart any adjacent pair closer than the requested gap.
module lsp_expand_2 #(
  parameter logic [10:0] BUF_ADDR = 11'h100,
  parameter int          NC       = 5,
  parameter int          M        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] gap,
  input  logic [31:0] memIn,
  output logic [10:0] readAddr,
  output logic [10:0] writeAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic        done
);

  localparam logic [3:0] J_FIRST = 4'(NC);
  localparam logic [3:0] J_LAST  = 4'(M - 1);

  typedef enum logic [3:0] {
    IDLE, RD_PREV, RD_CUR, CAPTURE, CALC, WR_PREV, WR_CUR, NEXT, DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  j_reg, j_next;
  logic [15:0] gap_reg, gap_next;
  logic [15:0] prev_raw_reg, prev_raw_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic [15:0] new_prev_reg, new_prev_next;
  logic [15:0] new_cur_reg, new_cur_next;

  logic [3:0]  j_prev;
  logic [10:0] addr_prev, addr_cur;
  logic [15:0] diff, tmp;
  logic        tmp_pos;
  logic        unused_hi;

  // 17-bit sums of sign-extended operands are exact; clamp back to Word16.
  function automatic logic [15:0] sat16(input logic [16:0] s);
    if (s[16] != s[15])
      sat16 = s[16] ? 16'h8000 : 16'h7FFF;
    else
      sat16 = s[15:0];
  endfunction

  function automatic logic [15:0] add16(input logic [15:0] x, input logic [15:0] y);
    add16 = sat16({x[15], x} + {y[15], y});
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] x, input logic [15:0] y);
    sub16 = sat16({x[15], x} - {y[15], y});
  endfunction

  assign unused_hi = ^memIn[31:16];
  assign j_prev    = j_reg - 4'd1;
  assign addr_prev = {BUF_ADDR[10:4], j_prev};
  assign addr_cur  = {BUF_ADDR[10:4], j_reg};

  assign diff    = add16(sub16(a_reg, b_reg), gap_reg);
  assign tmp     = {diff[15], diff[15:1]};
  assign tmp_pos = !tmp[15] && (tmp != 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      j_reg        <= J_FIRST;
      gap_reg      <= 16'd0;
      prev_raw_reg <= 16'd0;
      a_reg        <= 16'd0;
      b_reg        <= 16'd0;
      new_prev_reg <= 16'd0;
      new_cur_reg  <= 16'd0;
    end else begin
      state_reg    <= state_next;
      j_reg        <= j_next;
      gap_reg      <= gap_next;
      prev_raw_reg <= prev_raw_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      new_prev_reg <= new_prev_next;
      new_cur_reg  <= new_cur_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    j_next        = j_reg;
    gap_next      = gap_reg;
    prev_raw_next = prev_raw_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    new_prev_next = new_prev_reg;
    new_cur_next  = new_cur_reg;
    readAddr      = 11'd0;
    writeAddr     = 11'd0;
    memOut        = 32'd0;
    memWriteEn    = 1'b0;
    done          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RD_PREV;
          j_next     = J_FIRST;
          gap_next   = gap;
        end
      end
      RD_PREV: begin
        readAddr   = addr_prev;
        state_next = RD_CUR;
      end
      RD_CUR: begin
        // buf[j-1] arrives now, one cycle after its address.
        readAddr      = addr_cur;
        prev_raw_next = memIn[15:0];
        state_next    = CAPTURE;
      end
      CAPTURE: begin
        a_next     = prev_raw_reg;
        b_next     = memIn[15:0];
        state_next = CALC;
      end
      CALC: begin
        new_prev_next = sub16(a_reg, tmp);
        new_cur_next  = add16(b_reg, tmp);
        state_next    = tmp_pos ? WR_PREV : NEXT;
      end
      WR_PREV: begin
        writeAddr  = addr_prev;
        memOut     = {{16{new_prev_reg[15]}}, new_prev_reg};
        memWriteEn = 1'b1;
        state_next = WR_CUR;
      end
      WR_CUR: begin
        writeAddr  = addr_cur;
        memOut     = {{16{new_cur_reg[15]}}, new_cur_reg};
        memWriteEn = 1'b1;
        state_next = NEXT;
      end
      NEXT: begin
        if (j_reg == J_LAST) begin
          state_next = DONE;
        end else begin
          j_next     = j_reg + 4'd1;
          state_next = RD_PREV;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = RD_PREV;
          j_next     = J_FIRST;
          gap_next   = gap;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
